// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shared shift/add-subtract datapath, 1 bit per cycle.
// Produces {hi,lo} for MULT/MULTU/DIV/DIVU with start/ready handshake, annul and div-by-zero.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 div_zero_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               div_zero_q, div_zero_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, mul_fix, div_fix;
  logic [WIDTH-1:0]   div_rem, quo_fix, rem_fix;
  logic               div_ok, cnt_last;

  assign signed_op = ~op_i[0];
  assign a_neg     = signed_op & opdata1_i[WIDTH-1];
  assign b_neg     = signed_op & opdata2_i[WIDTH-1];
  assign a_mag     = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign b_mag     = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;

  // Multiply: acc = {partial hi, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_fix  = neg_lo_q ? (~mul_next + 1'b1) : mul_next;

  // Restoring divide: acc = {remainder, dividend bits / quotient bits}, shifted left each step.
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
  assign div_ok    = ~div_trial[WIDTH];
  assign div_rem   = div_ok ? div_trial[WIDTH-1:0] : {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]};
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ok};
  assign quo_fix   = neg_lo_q ? (~div_next[WIDTH-1:0] + 1'b1) : div_next[WIDTH-1:0];
  assign rem_fix   = neg_hi_q ? (~div_next[2*WIDTH-1:WIDTH] + 1'b1)
                              : div_next[2*WIDTH-1:WIDTH];
  assign div_fix   = {rem_fix, quo_fix};

  assign cnt_last  = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    result_d   = result_q;
    opnd_d     = opnd_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      StIdle: begin
        if (start_i && !annul_i) begin
          cnt_d      = '0;
          neg_lo_d   = a_neg ^ b_neg;
          div_zero_d = 1'b0;
          if (op_i[1]) begin
            acc_d    = {{WIDTH{1'b0}}, a_mag};
            opnd_d   = b_mag;
            neg_hi_d = a_neg;
            if (opdata2_i == '0) begin
              state_d    = StDone;
              result_d   = {opdata1_i, {WIDTH{1'b1}}};
              div_zero_d = 1'b1;
            end else begin
              state_d = StDiv;
            end
          end else begin
            acc_d    = {{WIDTH{1'b0}}, b_mag};
            opnd_d   = a_mag;
            neg_hi_d = 1'b0;
            state_d  = StMul;
          end
        end
      end
      StMul: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_last) begin
          state_d  = StDone;
          result_d = mul_fix;
        end
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_last) begin
          state_d  = StDone;
          result_d = div_fix;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Flush overrides everything; the visible result is left as it was.
    if (annul_i) begin
      state_d    = StIdle;
      result_d   = result_q;
      div_zero_d = div_zero_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      opnd_q     <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      opnd_q     <= opnd_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign ready_o    = (state_q == StDone);
  assign div_zero_o = ready_o & div_zero_q;
  assign result_o   = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table for WIDTH=32 plus handshake/annul/reset sequences
// and a small WIDTH=8 instance.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, annul;
  logic [1:0]  op;
  logic [31:0] d1, d2;
  logic        busy, ready, dz;
  logic [63:0] result;

  logic        rst8, start8, annul8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, ready8, dz8;
  logic [15:0] result8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .opdata1_i(d1), .opdata2_i(d2),
    .annul_i(annul), .busy_o(busy), .ready_o(ready), .result_o(result), .div_zero_o(dz)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .start_i(start8), .op_i(op8), .opdata1_i(a8), .opdata2_i(b8),
    .annul_i(annul8), .busy_o(busy8), .ready_o(ready8), .result_o(result8), .div_zero_o(dz8)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a request; returns in cycle 1 (the cycle after the accepting edge).
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; d1 = a; d2 = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_ready(input int c0, output int lat, output logic [63:0] res,
                            output logic z);
    lat = -1; res = '0; z = 1'b0;
    for (int c = c0; c <= 100; c++) begin
      @(negedge clk);
      if (ready) begin
        lat = c; res = result; z = dz;
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic count_ready(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
  endtask

  int          lat, pulses;
  logic [63:0] res;
  logic        z;

  initial begin
    rst = 1'b0; start = 1'b0; annul = 1'b0; op = '0; d1 = '0; d2 = '0;
    rst8 = 1'b0; start8 = 1'b0; annul8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;

    vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 33};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 33};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 33};
    vecs[3]  = '{2'b11, 32'd100,      32'd7,        64'h00000002_0000000E, 1'b0, 33};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 33};
    vecs[5]  = '{2'b11, 32'd5,        32'd0,        64'h00000005_FFFFFFFF, 1'b1, 1};
    vecs[6]  = '{2'b00, 32'd7,        32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFD6, 1'b0, 33};
    vecs[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 33};
    vecs[8]  = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 1'b0, 33};
    vecs[9]  = '{2'b00, 32'h12345678, 32'd0,        64'h00000000_00000000, 1'b0, 33};
    vecs[10] = '{2'b01, 32'h80000000, 32'd2,        64'h00000001_00000000, 1'b0, 33};
    vecs[11] = '{2'b10, 32'hFFFFFFFF, 32'd0,        64'hFFFFFFFF_FFFFFFFF, 1'b1, 1};

    #1;
    check("reset_outputs", {60'd0, busy, ready, dz, |result}, 64'd0);
    check("reset_outputs8", {60'd0, busy8, ready8, dz8, |result8}, 64'd0);
    #20;
    @(negedge clk);
    rst = 1'b1; rst8 = 1'b1;

    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_ready(1, lat, res, z);
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_div_zero", i), {63'd0, z}, {63'd0, vecs[i].dz});
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      @(negedge clk);
      check($sformatf("vec%0d_after_done", i), {62'd0, ready, busy}, 64'd0);
    end

    // Annul a DIVU in cycle 10; result from the last vector must survive.
    launch(2'b11, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    check("annul_busy_before", {63'd0, busy}, 64'd1);
    @(posedge clk); #1 annul = 1'b0;
    @(negedge clk);
    check("annul_idle_after", {62'd0, ready, busy}, 64'd0);
    check("annul_result_kept", result, 64'hFFFFFFFF_FFFFFFFF);
    count_ready(40, pulses);
    check("annul_no_ready", 64'(pulses), 64'd0);

    // Annul and start together in IDLE: request is dropped.
    @(posedge clk); #1 start = 1'b1; annul = 1'b1; op = 2'b01; d1 = 32'd9; d2 = 32'd9;
    @(posedge clk); #1 start = 1'b0; annul = 1'b0;
    @(negedge clk);
    check("annul_start_dropped", {63'd0, busy}, 64'd0);

    // Start held high while busy (cycles 3..6) must not disturb the running MULTU.
    launch(2'b01, 32'd3, 32'd4);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; op = 2'b11; d1 = 32'd100; d2 = 32'd7;
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    wait_ready(7, lat, res, z);
    check("busy_start_result", res, 64'd12);
    check("busy_start_latency", 64'(lat), 64'd33);
    // Start only in the DONE cycle is ignored.
    #1 start = 1'b1; op = 2'b11; d1 = 32'd100; d2 = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    count_ready(40, pulses);
    check("done_start_ignored", 64'(pulses), 64'd0);
    check("done_start_idle", {63'd0, busy}, 64'd0);

    // WIDTH=8: signed MIN*MIN.
    @(posedge clk); #1 start8 = 1'b1; op8 = 2'b00; a8 = 8'h80; b8 = 8'h80;
    @(posedge clk); #1 start8 = 1'b0;
    lat = -1; res = '0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (ready8) begin
        lat = c; res = {48'd0, result8};
        break;
      end
      @(posedge clk);
    end
    check("w8_mult_result", res, 64'h4000);
    check("w8_mult_latency", 64'(lat), 64'd9);

    // WIDTH=8: asynchronous reset in the middle of an operation.
    @(posedge clk); #1 start8 = 1'b1; op8 = 2'b01; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst8 = 1'b0;
    #1;
    check("w8_async_reset", {44'd0, busy8, ready8, dz8, 1'b0, result8}, 64'd0);
    #10 rst8 = 1'b1;
    repeat (2) @(negedge clk);
    check("w8_idle_after_reset", {63'd0, busy8}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
